// File: rtl/dcache_region_router.sv
// Splits LSU data traffic between the D-cache and direct uncached memory access.
// Optional uncached watchdog enabled by defining DCACHE_ROUTER_UC_TIMEOUT_EN.
module dcache_region_router #(
    parameter int                 ADDR_W     = 32,
    parameter int                 CPU_DW     = 64,
    parameter int                 MEM_DW     = 128,
    parameter logic [ADDR_W-1:0]  CACHE_BASE = ADDR_W'(32'h8000_0000),
    parameter logic [ADDR_W-1:0]  CACHE_MASK = ADDR_W'(32'h8000_0000),
    parameter int                 TIMEOUT    = 1024
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_clean,

    input  logic              s_valid,
    output logic              s_ready,
    input  logic              s_reqtyp,
    input  logic [ADDR_W-1:0] s_addr,
    input  logic [CPU_DW-1:0] s_wdata,
    input  logic [2:0]        s_size,
    output logic [CPU_DW-1:0] s_rdata,
    output logic              s_err,

    output logic              c_valid,
    input  logic              c_ready,
    output logic              c_reqtyp,
    output logic [ADDR_W-1:0] c_addr,
    output logic [CPU_DW-1:0] c_wdata,
    output logic [2:0]        c_size,
    input  logic [CPU_DW-1:0] c_rdata,
    output logic              c_clean,

    input  logic              cm_valid,
    output logic              cm_ready,
    input  logic              cm_reqtyp,
    input  logic [ADDR_W-1:0] cm_addr,
    input  logic [MEM_DW-1:0] cm_wdata,
    input  logic [2:0]        cm_size,
    output logic [MEM_DW-1:0] cm_rdata,

    output logic              m_valid,
    input  logic              m_ready,
    output logic              m_reqtyp,
    output logic [ADDR_W-1:0] m_addr,
    output logic [MEM_DW-1:0] m_wdata,
    output logic [2:0]        m_size,
    input  logic [MEM_DW-1:0] m_rdata,
    output logic              m_cachable
);

    localparam int LANES = MEM_DW / CPU_DW;
    localparam int LW    = (LANES > 1) ? $clog2(LANES) : 1;
    localparam int OFF   = $clog2(CPU_DW / 8);

    typedef enum logic [1:0] {IDLE, CACHE, UNCACHE} state_t;

    state_t            state, state_nx;
    logic [LW-1:0]     lane, lane_nx, lane_dec;
    logic [ADDR_W-1:0] addr_sh;
    logic              cachable;
    logic              tmo;

    assign cachable = (s_addr & CACHE_MASK) == CACHE_BASE;
    assign addr_sh  = s_addr >> OFF;
    assign lane_dec = (LANES > 1) ? addr_sh[LW-1:0] : '0;

    // Cache payload is passed through; only the valid is gated by route.
    assign c_reqtyp = s_reqtyp;
    assign c_addr   = s_addr;
    assign c_wdata  = s_wdata;
    assign c_size   = s_size;
    assign c_clean  = i_clean;
    assign cm_rdata = m_rdata;

`ifdef DCACHE_ROUTER_UC_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT + 1);

    logic [CW-1:0] wd;

    assign tmo = (state == UNCACHE) && !m_ready
              && (wd == CW'(TIMEOUT - 1));

    always_ff @(posedge i_clk) begin
        if (i_rst)
            wd <= '0;
        else if (state == UNCACHE && !m_ready && !tmo)
            wd <= wd + 1'b1;
        else
            wd <= '0;
    end
`else
    assign tmo = 1'b0;
`endif

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state <= IDLE;
            lane  <= '0;
        end else begin
            state <= state_nx;
            lane  <= lane_nx;
        end
    end

    always_comb begin
        state_nx   = state;
        lane_nx    = lane;
        s_ready    = 1'b0;
        s_rdata    = '0;
        s_err      = 1'b0;
        c_valid    = 1'b0;
        cm_ready   = 1'b0;
        m_valid    = 1'b0;
        m_reqtyp   = 1'b0;
        m_addr     = '0;
        m_wdata    = '0;
        m_size     = '0;
        m_cachable = 1'b0;
        unique case (state)
            IDLE: begin
                if (i_clean || (s_valid && cachable)) begin
                    state_nx = CACHE;
                end else if (s_valid) begin
                    state_nx = UNCACHE;
                    lane_nx  = lane_dec;
                end
            end
            CACHE: begin
                c_valid    = s_valid;
                s_ready    = c_ready;
                s_rdata    = c_rdata;
                m_valid    = cm_valid;
                m_reqtyp   = cm_reqtyp;
                m_addr     = cm_addr;
                m_wdata    = cm_wdata;
                m_size     = cm_size;
                cm_ready   = m_ready;
                m_cachable = 1'b1;
                if (c_ready)
                    state_nx = IDLE;
            end
            UNCACHE: begin
                m_valid  = s_valid && !tmo;
                m_reqtyp = s_reqtyp;
                m_addr   = s_addr;
                m_size   = s_size;
                m_wdata  = {LANES{s_wdata}};
                if (m_ready) begin
                    s_ready  = 1'b1;
                    s_rdata  = m_rdata[lane*CPU_DW +: CPU_DW];
                    state_nx = IDLE;
                end else if (tmo) begin
                    s_ready  = 1'b1;
                    s_err    = 1'b1;
                    s_rdata  = '1;
                    state_nx = IDLE;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

endmodule
